// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: aluop/alusel codes, exception causes, FSM states.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package ex_stage_pkg;

  // Specific operation codes carried on aluop
  localparam logic [7:0] ALUOP_NOP  = 8'h00;
  localparam logic [7:0] ALUOP_ADD  = 8'h01;
  localparam logic [7:0] ALUOP_SUB  = 8'h02;
  localparam logic [7:0] ALUOP_AND  = 8'h03;
  localparam logic [7:0] ALUOP_OR   = 8'h04;
  localparam logic [7:0] ALUOP_XOR  = 8'h05;
  localparam logic [7:0] ALUOP_BEQ  = 8'h10;
  localparam logic [7:0] ALUOP_BNE  = 8'h11;
  localparam logic [7:0] ALUOP_BLT  = 8'h12;
  localparam logic [7:0] ALUOP_BGE  = 8'h13;
  localparam logic [7:0] ALUOP_BLTU = 8'h14;
  localparam logic [7:0] ALUOP_BGEU = 8'h15;
  localparam logic [7:0] ALUOP_LW   = 8'h20;
  localparam logic [7:0] ALUOP_SW   = 8'h21;
  localparam logic [7:0] ALUOP_JAL  = 8'h30;
  localparam logic [7:0] ALUOP_JALR = 8'h31;

  // Operation classes carried on alusel. Nine classes share a 3-bit field, so
  // R and I use the same code: decode has already placed the immediate in reg2
  // for I-type, and both classes execute identically here.
  localparam logic [2:0] ALUSEL_NOP  = 3'd0;
  localparam logic [2:0] ALUSEL_R    = 3'd1;
  localparam logic [2:0] ALUSEL_I    = 3'd1;
  localparam logic [2:0] ALUSEL_B    = 3'd2;
  localparam logic [2:0] ALUSEL_NB   = 3'd3;
  localparam logic [2:0] ALUSEL_LW   = 3'd4;
  localparam logic [2:0] ALUSEL_SW   = 3'd5;
  localparam logic [2:0] ALUSEL_JAL  = 3'd6;
  localparam logic [2:0] ALUSEL_JALR = 3'd7;

  // Exception causes reported on exc_cause
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM_WAIT,
    S_DONE
  } ex_state_t;

  // Word accesses must have the two low address bits clear
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of the execute-stage decoded-op handshake, memory port and result pulses.
// Latency: n/a (wires only).
// Backpressure: in_ready gates decoded ops; mem_req is held until mem_ack.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc_i;
  logic [7:0]      aluop_i;
  logic [2:0]      alusel_i;
  logic [XLEN-1:0] reg1_i;
  logic [XLEN-1:0] reg2_i;
  logic [XLEN-1:0] imm_i;
  logic [4:0]      wd_i;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            br_valid;
  logic [XLEN-1:0] br_target;

  logic            exc_valid;
  logic [1:0]      exc_cause;

  // Environment side: decode stage, data memory and result consumers
  modport master (
    output in_valid, pc_i, aluop_i, alusel_i, reg1_i, reg2_i, imm_i, wd_i,
    output mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_addr, wb_data, br_valid, br_target, exc_valid, exc_cause
  );

  // Execute stage side
  modport slave (
    input  in_valid, pc_i, aluop_i, alusel_i, reg1_i, reg2_i, imm_i, wd_i,
    input  mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_addr, wb_data, br_valid, br_target, exc_valid, exc_cause
  );
endinterface

// File: rtl/ex_alu.sv
// Integer ALU for R/I-class ops: ADD, SUB, AND, OR, XOR; flags any other aluop as illegal.
// Latency: combinational.
// Backpressure: none.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [7:0]      aluop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  // Select the operation; arithmetic wraps naturally at XLEN bits
  always_comb begin
    result  = XLEN'(ZeroWord);
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: result = a + b;
      ALUOP_SUB: result = a - b;
      ALUOP_AND: result = a & b;
      ALUOP_OR:  result = a | b;
      ALUOP_XOR: result = a ^ b;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump target, load/store with a held memory request, one-cycle result pulses.
// Latency: 2 cycles accept-to-pulse for non-memory ops; memory ops add one cycle per extra req cycle before ack.
// Backpressure: in_ready only in IDLE (one op every 3 cycles); mem_req/addr/wdata held until mem_ack.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ex_stage_if.slave  bus
);

  ex_state_t       state;

  // Operands captured at the handshake, stable for the life of the op
  logic [XLEN-1:0] pc_q;
  logic [7:0]      aluop_q;
  logic [2:0]      alusel_q;
  logic [XLEN-1:0] reg1_q;
  logic [XLEN-1:0] reg2_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      wd_q;

  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;
  logic [XLEN-1:0] base_sum;   // reg1 + imm: load/store address and JALR target
  logic [XLEN-1:0] pc_rel;     // pc + imm: branch and JAL target
  logic [XLEN-1:0] link;       // return address written by JAL/JALR

  ex_alu #(.XLEN(XLEN)) u_alu (
    .aluop   (aluop_q),
    .a       (reg1_q),
    .b       (reg2_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign base_sum = reg1_q + imm_q;
  assign pc_rel   = pc_q + imm_q;
  assign link     = pc_q + XLEN'(4);

  // Control FSM with all outputs registered; pulses are set entering DONE and cleared leaving it
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc_q          <= XLEN'(ZeroWord);
      aluop_q       <= ALUOP_NOP;
      alusel_q      <= ALUSEL_NOP;
      reg1_q        <= XLEN'(ZeroWord);
      reg2_q        <= XLEN'(ZeroWord);
      imm_q         <= XLEN'(ZeroWord);
      wd_q          <= 5'd0;
      bus.in_ready  <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= XLEN'(ZeroWord);
      bus.mem_wdata <= XLEN'(ZeroWord);
      bus.wb_valid  <= 1'b0;
      bus.wb_addr   <= 5'd0;
      bus.wb_data   <= XLEN'(ZeroWord);
      bus.br_valid  <= 1'b0;
      bus.br_target <= XLEN'(ZeroWord);
      bus.exc_valid <= 1'b0;
      bus.exc_cause <= EXC_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            pc_q         <= bus.pc_i;
            aluop_q      <= bus.aluop_i;
            alusel_q     <= bus.alusel_i;
            reg1_q       <= bus.reg1_i;
            reg2_q       <= bus.reg2_i;
            imm_q        <= bus.imm_i;
            wd_q         <= bus.wd_i;
            bus.in_ready <= 1'b0;
            state        <= S_EXEC;
          end
        end

        S_EXEC: begin
          state <= S_DONE;
          case (alusel_q)
            ALUSEL_R: begin  // also covers ALUSEL_I
              if (alu_illegal) begin
                bus.exc_valid <= 1'b1;
                bus.exc_cause <= EXC_ILLEGAL;
              end else begin
                bus.wb_valid <= (wd_q != 5'd0);
                bus.wb_addr  <= wd_q;
                bus.wb_data  <= alu_result;
              end
            end
            ALUSEL_B: begin
              bus.br_valid  <= 1'b1;
              bus.br_target <= pc_rel;
            end
            ALUSEL_JAL: begin
              bus.br_valid  <= 1'b1;
              bus.br_target <= pc_rel;
              bus.wb_valid  <= (wd_q != 5'd0);
              bus.wb_addr   <= wd_q;
              bus.wb_data   <= link;
            end
            ALUSEL_JALR: begin
              bus.br_valid  <= 1'b1;
              bus.br_target <= {base_sum[XLEN-1:1], 1'b0};
              bus.wb_valid  <= (wd_q != 5'd0);
              bus.wb_addr   <= wd_q;
              bus.wb_data   <= link;
            end
            ALUSEL_LW, ALUSEL_SW: begin
              if (!word_aligned(base_sum[1:0])) begin
                bus.exc_valid <= 1'b1;
                bus.exc_cause <= EXC_MISALIGN;
              end else begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= (alusel_q == ALUSEL_SW);
                bus.mem_addr  <= base_sum;
                bus.mem_wdata <= (alusel_q == ALUSEL_SW) ? reg2_q : XLEN'(ZeroWord);
                state         <= S_MEM_WAIT;
              end
            end
            default: ;  // NOP, not-taken branch: complete silently
          endcase
        end

        S_MEM_WAIT: begin
          // Request fields stay untouched until the ack; ack is only looked at here, where mem_req is high
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (alusel_q == ALUSEL_LW) begin
              bus.wb_valid <= (wd_q != 5'd0);
              bus.wb_addr  <= wd_q;
              bus.wb_data  <= bus.mem_rdata;
            end
            state <= S_DONE;
          end
        end

        S_DONE: begin
          bus.wb_valid  <= 1'b0;
          bus.br_valid  <= 1'b0;
          bus.exc_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          bus.in_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle classes, hand sequences for memory and reset.
// Latency: checks pulses exactly at DONE and cleared one cycle later.
// Backpressure: drives in_valid only in IDLE, models memory ack timing directly.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [4:0]  wd;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        brv;
    logic [31:0] brt;
    logic        excv;
    logic [1:0]  excc;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.pc_i      = 32'h0;
    bus.aluop_i   = ALUOP_NOP;
    bus.alusel_i  = ALUSEL_NOP;
    bus.reg1_i    = 32'h0;
    bus.reg2_i    = 32'h0;
    bus.imm_i     = 32'h0;
    bus.wd_i      = 5'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic drive_op(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                          input logic [4:0] wd);
    bus.alusel_i = sel;
    bus.aluop_i  = op;
    bus.pc_i     = pc;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.imm_i    = imm;
    bus.wd_i     = wd;
    bus.in_valid = 1'b1;
  endtask

  // One non-memory op: accept, check the DONE pulses two edges later, check they clear
  task automatic run_vec(input vec_t v, input int idx);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("v%0d ready_before", idx), bus.in_ready, 1);
    drive_op(v.alusel, v.aluop, v.pc, v.reg1, v.reg2, v.imm, v.wd);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk($sformatf("v%0d exec_wb_valid", idx), bus.wb_valid, 0);
    chk($sformatf("v%0d exec_in_ready", idx), bus.in_ready, 0);
    @(negedge clk);
    chk($sformatf("v%0d wb_valid", idx), bus.wb_valid, v.wbv);
    if (v.wbv) begin
      chk($sformatf("v%0d wb_addr", idx), bus.wb_addr, v.wba);
      chk($sformatf("v%0d wb_data", idx), bus.wb_data, v.wbd);
    end
    chk($sformatf("v%0d br_valid", idx), bus.br_valid, v.brv);
    if (v.brv) chk($sformatf("v%0d br_target", idx), bus.br_target, v.brt);
    chk($sformatf("v%0d exc_valid", idx), bus.exc_valid, v.excv);
    if (v.excv) chk($sformatf("v%0d exc_cause", idx), bus.exc_cause, v.excc);
    chk($sformatf("v%0d mem_req", idx), bus.mem_req, 0);
    @(negedge clk);
    chk($sformatf("v%0d wb_clear", idx), bus.wb_valid, 0);
    chk($sformatf("v%0d br_clear", idx), bus.br_valid, 0);
    chk($sformatf("v%0d exc_clear", idx), bus.exc_valid, 0);
    chk($sformatf("v%0d ready_after", idx), bus.in_ready, 1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    //            sel          op          pc            reg1          reg2          imm           wd     wbv wba    wbd           brv brt           excv excc
    vecs[0]  = '{ALUSEL_R,    ALUOP_ADD,  32'h0,        32'h7FFFFFFF, 32'h1,        32'h0,        5'd5,  1, 5'd5,  32'h80000000, 0, 32'h0,        0, EXC_NONE};
    vecs[1]  = '{ALUSEL_R,    ALUOP_SUB,  32'h0,        32'h0,        32'h1,        32'h0,        5'd3,  1, 5'd3,  32'hFFFFFFFF, 0, 32'h0,        0, EXC_NONE};
    vecs[2]  = '{ALUSEL_R,    ALUOP_AND,  32'h0,        32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd2,  1, 5'd2,  32'h00F000F0, 0, 32'h0,        0, EXC_NONE};
    vecs[3]  = '{ALUSEL_R,    ALUOP_OR,   32'h0,        32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd4,  1, 5'd4,  32'hFFF0FFF0, 0, 32'h0,        0, EXC_NONE};
    vecs[4]  = '{ALUSEL_I,    ALUOP_XOR,  32'h0,        32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd31, 1, 5'd31, 32'hFF00FF00, 0, 32'h0,        0, EXC_NONE};
    vecs[5]  = '{ALUSEL_I,    ALUOP_ADD,  32'h0,        32'h5,        32'h7,        32'h7,        5'd0,  0, 5'd0,  32'h0,        0, 32'h0,        0, EXC_NONE};
    vecs[6]  = '{ALUSEL_B,    ALUOP_BEQ,  32'h100,      32'h0,        32'h0,        32'hFFFFFFF0, 5'd0,  0, 5'd0,  32'h0,        1, 32'h000000F0, 0, EXC_NONE};
    vecs[7]  = '{ALUSEL_NB,   ALUOP_BNE,  32'h100,      32'h1,        32'h2,        32'h40,       5'd0,  0, 5'd0,  32'h0,        0, 32'h0,        0, EXC_NONE};
    vecs[8]  = '{ALUSEL_JAL,  ALUOP_JAL,  32'h200,      32'h0,        32'h0,        32'h20,       5'd1,  1, 5'd1,  32'h204,      1, 32'h220,      0, EXC_NONE};
    vecs[9]  = '{ALUSEL_JALR, ALUOP_JALR, 32'h100,      32'h203,      32'h0,        32'h4,        5'd1,  1, 5'd1,  32'h104,      1, 32'h206,      0, EXC_NONE};
    vecs[10] = '{ALUSEL_R,    ALUOP_BEQ,  32'h0,        32'h1,        32'h1,        32'h0,        5'd4,  0, 5'd0,  32'h0,        0, 32'h0,        1, EXC_ILLEGAL};
    vecs[11] = '{ALUSEL_NOP,  ALUOP_NOP,  32'h40,       32'h1,        32'h2,        32'h3,        5'd6,  0, 5'd0,  32'h0,        0, 32'h0,        0, EXC_NONE};
    vecs[12] = '{ALUSEL_SW,   ALUOP_SW,   32'h0,        32'h1002,     32'h55,       32'h0,        5'd0,  0, 5'd0,  32'h0,        0, 32'h0,        1, EXC_MISALIGN};
    vecs[13] = '{ALUSEL_LW,   ALUOP_LW,   32'h0,        32'h1001,     32'h0,        32'h0,        5'd7,  0, 5'd0,  32'h0,        0, 32'h0,        1, EXC_MISALIGN};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready",  bus.in_ready,  1);
    chk("rst mem_req",   bus.mem_req,   0);
    chk("rst mem_we",    bus.mem_we,    0);
    chk("rst wb_valid",  bus.wb_valid,  0);
    chk("rst br_valid",  bus.br_valid,  0);
    chk("rst exc_valid", bus.exc_valid, 0);
    chk("rst mem_addr",  bus.mem_addr,  0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst wb_addr",   bus.wb_addr,   0);
    chk("rst wb_data",   bus.wb_data,   0);
    chk("rst br_target", bus.br_target, 0);
    chk("rst exc_cause", bus.exc_cause, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // LW: request held for three cycles, ack on the third, then load data written back
    drive_op(ALUSEL_LW, ALUOP_LW, 32'h0, 32'h1000, 32'h8, 32'h8, 5'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("lw exec mem_req", bus.mem_req, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("lw wait%0d mem_req", c),  bus.mem_req,  1);
      chk($sformatf("lw wait%0d mem_addr", c), bus.mem_addr, 32'h1008);
      chk($sformatf("lw wait%0d mem_we", c),   bus.mem_we,   0);
      chk($sformatf("lw wait%0d wb_valid", c), bus.wb_valid, 0);
      if (c == 2) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("lw done mem_req",  bus.mem_req,  0);
    chk("lw done wb_valid", bus.wb_valid, 1);
    chk("lw done wb_addr",  bus.wb_addr,  7);
    chk("lw done wb_data",  bus.wb_data,  32'hDEADBEEF);
    @(negedge clk);
    chk("lw after wb_valid", bus.wb_valid, 0);
    chk("lw after in_ready", bus.in_ready, 1);

    // SW aligned: store request with write data, immediate ack, no writeback
    drive_op(ALUSEL_SW, ALUOP_SW, 32'h0, 32'h2000, 32'hCAFEF00D, 32'h4, 5'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sw mem_req",   bus.mem_req,   1);
    chk("sw mem_we",    bus.mem_we,    1);
    chk("sw mem_addr",  bus.mem_addr,  32'h2004);
    chk("sw mem_wdata", bus.mem_wdata, 32'hCAFEF00D);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("sw done mem_req",   bus.mem_req,   0);
    chk("sw done wb_valid",  bus.wb_valid,  0);
    chk("sw done exc_valid", bus.exc_valid, 0);
    @(negedge clk);
    chk("sw after in_ready", bus.in_ready, 1);

    // Reset while waiting on memory: request drops, a late ack is ignored
    drive_op(ALUSEL_LW, ALUOP_LW, 32'h0, 32'h3000, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstw mem_req_before", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw mem_req",  bus.mem_req,  0);
    chk("rstw in_ready", bus.in_ready, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstw ack%0d mem_req", c),  bus.mem_req,  0);
      chk($sformatf("rstw ack%0d wb_valid", c), bus.wb_valid, 0);
    end
    bus.mem_ack = 1'b0;

    // Back-to-back: in_valid held high, one ADD completes every third cycle
    cnt = 0;
    drive_op(ALUSEL_R, ALUOP_ADD, 32'h0, 32'h1, 32'h1, 32'h0, 5'd9);
    repeat (9) begin
      @(negedge clk);
      if (bus.wb_valid === 1'b1) cnt++;
    end
    bus.in_valid = 1'b0;
    chk("b2b pulse_count", cnt, 3);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath and PC width.
REQ-002 Reset is rst, synchronous, active-high.
REQ-003 clk  in  1: rising-edge clock.
REQ-004 rst  in  1: synchronous active-high reset.
REQ-005 in_valid  in  1 / in_ready  out  1: decoded-op handshake; transfer occurs when both are high at a rising edge.
REQ-006 pc_i  in  XLEN; aluop_i  in  8; alusel_i  in  3: PC, specific operation and operation class of the decoded instruction.
REQ-007 reg1_i, reg2_i, imm_i  in  XLEN; wd_i  in  5: operands, immediate and destination register.
REQ-008 mem_req  out  1; mem_we  out  1; mem_addr  out  XLEN; mem_wdata  out  XLEN: data-memory request, held until acknowledged.
REQ-009 mem_ack  in  1; mem_rdata  in  XLEN: memory completion and load data.
REQ-010 wb_valid  out  1; wb_addr  out  5; wb_data  out  XLEN: register-file write, one-cycle pulse.
REQ-011 br_valid  out  1; br_target  out  XLEN: PC redirect, one-cycle pulse.
REQ-012 exc_valid  out  1; exc_cause  out  2: exception pulse; cause 1 = misaligned address, 2 = illegal aluop.

Function
REQ-013 FSM states: IDLE, EXEC, MEM_WAIT, DONE; in_ready is high only in IDLE.
REQ-014 IDLE: a handshake registers all inputs and moves to EXEC; without a handshake the FSM stays in IDLE.
REQ-015 EXEC, class R or I: ADD = reg1+reg2, SUB = reg1-reg2, AND/OR/XOR bitwise on reg1 and reg2; arithmetic wraps modulo 2^XLEN.
REQ-016 EXEC, class R or I: result and wd are registered, and the FSM goes to DONE.
REQ-017 EXEC, class B (taken): br_target = pc+imm, br_valid pulses in DONE, and no writeback occurs.
REQ-018 EXEC, class NB (not taken): nothing is asserted in DONE.
REQ-019 EXEC, class JAL: br_target = pc+imm, link = pc+4.
REQ-020 EXEC, class JALR: br_target = (reg1+imm) with bit 0 cleared, link = pc+4.
REQ-021 For JAL and JALR, both br_valid and wb_valid (data = link) pulse in DONE.
REQ-022 EXEC, class LW: address = reg1+imm (reg2 carries imm).
REQ-023 EXEC, class SW: address = reg1+imm, mem_wdata = reg2.
REQ-024 EXEC, LW or SW: if address[1:0] != 0, no request is issued, exc_valid pulses in DONE with cause 1, and no writeback occurs.
REQ-025 EXEC, LW or SW with an aligned address: mem_req is registered high with mem_we = 1 for SW and 0 for LW, and the FSM enters MEM_WAIT.
REQ-026 MEM_WAIT: mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
REQ-027 On mem_ack, mem_req drops at the next edge, the LW captures mem_rdata, and the FSM goes to DONE.
REQ-028 mem_ack is ignored while mem_req is low.
REQ-029 DONE lasts exactly one cycle, during which the pulses in REQ-010 to REQ-012 are asserted; the FSM then returns to IDLE.
REQ-030 Latency from an accepting edge to the DONE pulse: 2 cycles for non-memory classes; 3 + (edges of mem_req high before ack) for memory classes.
REQ-031 Back-to-back throughput: one non-memory instruction every 3 cycles.
REQ-032 Writes with wd = 0 are suppressed: wb_valid stays low.
REQ-033 An aluop not listed for classes R or I gives no writeback and an exc_valid pulse with cause 2.
REQ-034 Class NOP is accepted and completes with no pulses.
REQ-035 An unrecognized alusel is treated as NOP.

Reset
REQ-036 rst takes priority over all other inputs; FSM returns to IDLE.
REQ-037 Reset values: in_ready = 1; all of mem_req, mem_we, wb_valid, br_valid and exc_valid = 0; all data/address outputs = 0.
REQ-038 Reset during MEM_WAIT drops mem_req at the reset edge, and any later mem_ack is ignored.

Structure
REQ-039 The shared defines file holds the aluop codes (NOP, ADD, SUB, AND, OR, XOR, BEQ..BGEU, LW, SW, JAL, JALR), the alusel codes (NOP, R, I, B, NB, LW, SW, JAL, JALR), exception causes and ZeroWord; none are redefined locally.
REQ-040 One combinational sub-module, ex_alu (aluop, a, b -> result, illegal), is instantiated once.

Verification
REQ-041 ADD, reg1=0x7FFFFFFF, reg2=1, wd=5 -> 2 cycles later wb_valid=1, wb_addr=5, wb_data=0x80000000 for 1 cycle.
REQ-042 JALR, pc=0x100, reg1=0x203, imm=4, wd=1 -> br_target=0x206, wb_data=0x104, with br_valid and wb_valid in the same cycle.
REQ-043 LW, reg1=0x1000, imm=8, mem_ack after 3 req cycles, mem_rdata=0xDEADBEEF, wd=7 -> mem_addr=0x1008 held stable, then wb_data=0xDEADBEEF.
REQ-044 SW, reg1=0x1002, imm=0 -> mem_req never rises; exc_valid=1, cause=1; no wb_valid.
REQ-045 ADDI, wd=0 -> wb_valid stays 0; NB class -> br_valid stays 0.
REQ-046 rst asserted during MEM_WAIT, then mem_ack=1 -> mem_req=0 after the reset edge, in_ready=1, no wb_valid.
